cla_seq_ctrl: RTL and testbench

- Multi-cycle sequencer that performs a DATA_WIDTH-bit add by time-multiplexing one external SLICE_WIDTH-bit CLA slice.
- Latches operands on a valid/ready handshake and feeds the slice one slice per cycle, LSB slice first, rippling the carry through an internal register.
- Assembles the sum and presents it on a valid/ready output.
- Replaces the fully unrolled adder wherever area matters more than latency.

---
 rtl/cla_seq_ctrl_if.sv | 16 +
 rtl/cla_seq_ctrl.sv | 90 +++++++++
 tb/tb_cla_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_seq_ctrl_if.sv
// cla_seq_ctrl_if: operand/result valid-ready bundle shared by cla_seq_ctrl and its driver
interface cla_seq_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  ci;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] s;
    logic                  co;
    modport master(output in_valid, a, b, ci, out_ready, input in_ready, out_valid, s, co);
    modport slave(input in_valid, a, b, ci, out_ready, output in_ready, out_valid, s, co);
endinterface

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: multi-cycle adder time-multiplexing one external CLA slice; CLA_SEQ_OVF_EN adds signed overflow output ovf
module cla_seq_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cla_seq_ctrl_if.slave          bus,
    output logic                   busy,
    output logic [SLICE_WIDTH-1:0] slice_a,
    output logic [SLICE_WIDTH-1:0] slice_b,
    output logic                   slice_ci,
    input  logic [SLICE_WIDTH-1:0] slice_s,
    input  logic                   slice_co
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic                   ovf
`endif
);
    localparam int NSLICE = DATA_WIDTH / SLICE_WIDTH;
    localparam int CNT_W = NSLICE > 1 ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                               state;
    state_t                               next;
    logic   [NSLICE-1:0][SLICE_WIDTH-1:0] a_q;
    logic   [NSLICE-1:0][SLICE_WIDTH-1:0] b_q;
    logic   [NSLICE-1:0][SLICE_WIDTH-1:0] s_q;
    logic   [CNT_W-1:0]                   idx;
    logic                                 carry_q;
    logic                                 co_q;
    logic                                 last;
    logic                                 accept;

    assign last   = idx == LAST;
    assign accept = state == IDLE && bus.in_valid;
    assign bus.s  = s_q;
    assign bus.co = co_q;

    always_ff @(posedge clk) state <= rst_n ? next : IDLE;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = bus.in_valid ? RUN : IDLE;
            RUN:     next = last ? DONE : RUN;
            DONE:    next = bus.out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
        busy          = state != IDLE;
        slice_a       = state == RUN ? a_q[idx] : '0;
        slice_b       = state == RUN ? b_q[idx] : '0;
        slice_ci      = state == RUN && carry_q;
    end

    // the slice sum is combinational, so each RUN edge commits one slice and the ripple carry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.ci;
            idx     <= '0;
        end else if (state == RUN) begin
            s_q[idx] <= slice_s;
            carry_q  <= slice_co;
            if (last) co_q <= slice_co;
            else idx <= idx + 1'b1;
        end
    end

`ifdef CLA_SEQ_OVF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) ovf <= 1'b0;
        else if (state == RUN && last)
            ovf <= (a_q[NSLICE-1][SLICE_WIDTH-1] == b_q[NSLICE-1][SLICE_WIDTH-1]) &&
                   (slice_s[SLICE_WIDTH-1] != a_q[NSLICE-1][SLICE_WIDTH-1]);
    end
`endif
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl: directed and random bench for cla_seq_ctrl with an arithmetic reference model
module tb_cla_seq_ctrl;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int N = DW / SW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_seq_ctrl_if #(.DATA_WIDTH(DW)) bus ();
    logic          busy;
    logic [SW-1:0] slice_a, slice_b, slice_s;
    logic          slice_ci, slice_co;
    assign {slice_co, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{SW{1'b0}}, slice_ci};

    cla_seq_ctrl_if #(.DATA_WIDTH(DW)) bus1 ();
    logic          busy1;
    logic [DW-1:0] sa1, sb1, ss1;
    logic          sci1, sco1;
    assign {sco1, ss1} = {1'b0, sa1} + {1'b0, sb1} + {{DW{1'b0}}, sci1};

`ifdef CLA_SEQ_OVF_EN
    logic ovf, ovf1;
`endif

    cla_seq_ctrl #(.DATA_WIDTH(DW), .SLICE_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy),
        .slice_a(slice_a), .slice_b(slice_b), .slice_ci(slice_ci),
        .slice_s(slice_s), .slice_co(slice_co)
`ifdef CLA_SEQ_OVF_EN
        , .ovf(ovf)
`endif
    );

    cla_seq_ctrl #(.DATA_WIDTH(DW), .SLICE_WIDTH(DW)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .busy(busy1),
        .slice_a(sa1), .slice_b(sb1), .slice_ci(sci1),
        .slice_s(ss1), .slice_co(sco1)
`ifdef CLA_SEQ_OVF_EN
        , .ovf(ovf1)
`endif
    );

    int vecs = 0;
    int errs = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // reference model: transaction timestamps plus plain wide arithmetic
    int          cyc = 0;
    int          acc = 0;
    bit          m_act = 0;
    bit          s_known = 0;
    logic [63:0] m_a = 0, m_b = 0, m_sum = 0;
    logic        m_ci = 0;
    bit          m_ovf = 0;

    always @(posedge clk) begin
        longint sv;
        if (!rst_n) begin
            m_act = 0; s_known = 1; m_sum = 0; m_ovf = 0;
        end else if (m_act && cyc >= acc + N && bus.out_ready) begin
            m_act = 0; s_known = 1;
        end else if (!m_act && bus.in_valid) begin
            m_act = 1; acc = cyc + 1; s_known = 0;
            m_a = 64'(bus.a); m_b = 64'(bus.b); m_ci = bus.ci;
            m_sum = m_a + m_b + 64'(m_ci);
            sv = longint'($signed(bus.a)) + longint'($signed(bus.b)) + longint'(m_ci);
            m_ovf = sv > 64'sd2147483647 || sv < -64'sd2147483648;
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit          done, run;
        int          k;
        logic [63:0] msk, ea, eb, ec;
        done = m_act && cyc >= acc + N;
        run  = m_act && !done;
        k    = run ? cyc - acc : 0;
        msk  = (64'd1 << (SW * k)) - 64'd1;
        ea   = run ? (m_a >> (SW * k)) & ((64'd1 << SW) - 64'd1) : 64'd0;
        eb   = run ? (m_b >> (SW * k)) & ((64'd1 << SW) - 64'd1) : 64'd0;
        ec   = run ? ((m_a & msk) + (m_b & msk) + 64'(m_ci)) >> (SW * k) : 64'd0;
        chk("in_ready", 64'(bus.in_ready), 64'(!m_act));
        chk("busy", 64'(busy), 64'(m_act));
        chk("out_valid", 64'(bus.out_valid), 64'(done));
        chk("slice_a", 64'(slice_a), ea);
        chk("slice_b", 64'(slice_b), eb);
        chk("slice_ci", 64'(slice_ci), ec);
        if (s_known || done) begin
            chk("s", 64'(bus.s), m_sum & 64'hFFFF_FFFF);
            chk("co", 64'(bus.co), 64'(m_sum[32]));
`ifdef CLA_SEQ_OVF_EN
            chk("ovf", 64'(ovf), 64'(m_ovf));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        int t = 0;
        while (!bus.in_ready && t < 100) begin tick(); t++; end
        chk("accept_wait", 64'(bus.in_ready), 64'd1);
        bus.a = av; bus.b = bv; bus.ci = cv; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 100) begin tick(); n++; end
    endtask

    task automatic collect(input string nm, input logic [31:0] es, input logic eco, input logic eovf);
        int n;
        wait_valid(n);
        chk({nm, "_lat"}, 64'(n), 64'd8);
        chk({nm, "_s"}, 64'(bus.s), 64'(es));
        chk({nm, "_co"}, 64'(bus.co), 64'(eco));
`ifdef CLA_SEQ_OVF_EN
        chk({nm, "_ovf"}, 64'(ovf), 64'(eovf));
`else
        if (eovf === 1'bx) $display("note: ovf expectation unknown for %s", nm);
`endif
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic op1(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic [32:0] exp);
        int n = 0;
        chk("n1_in_ready", 64'(bus1.in_ready), 64'd1);
        bus1.a = av; bus1.b = bv; bus1.ci = cv; bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        chk("n1_busy", 64'(busy1), 64'd1);
        while (!bus1.out_valid && n < 10) begin tick(); n++; end
        chk("n1_lat", 64'(n), 64'd1);
        chk("n1_sum", 64'({bus1.co, bus1.s}), 64'(exp));
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        int  n, cnt, t;
        bit  popped;
        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.ci = 0; bus.out_ready = 0;
        bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.ci = 0; bus1.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s", 64'(bus.s), 64'd0);
        chk("rst_co", 64'(bus.co), 64'd0);

        accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        collect("v1", 32'h0000_0000, 1'b1, 1'b0);
        accept(32'h1234_5678, 32'h1111_1111, 1'b1);
        chk("v2_slice_a", 64'(slice_a), 64'h8);
        chk("v2_slice_b", 64'(slice_b), 64'h1);
        chk("v2_slice_ci", 64'(slice_ci), 64'h1);
        collect("v2", 32'h2345_678A, 1'b0, 1'b0);
        accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        collect("v3", 32'h8000_0000, 1'b0, 1'b1);
        accept(32'h8000_0000, 32'h8000_0000, 1'b0);
        collect("v4", 32'h0000_0000, 1'b1, 1'b1);
        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        collect("v5", 32'hFFFF_FFFF, 1'b1, 1'b0);

        // back-pressure with a competing request held during DONE
        accept(32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
        wait_valid(n);
        bus.a = 32'h1111_1111; bus.b = 32'h2222_2222; bus.ci = 1'b1; bus.in_valid = 1'b1;
        repeat (20) tick();
        chk("bp_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_s", 64'(bus.s), 64'hDFAE_BFF0);
        chk("bp_co", 64'(bus.co), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_idle_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_idle_valid", 64'(bus.out_valid), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_accept_busy", 64'(busy), 64'd1);
        collect("bp2", 32'h3333_3334, 1'b0, 1'b0);

        // reset during RUN cycle 3
        accept(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_s", 64'(bus.s), 64'd0);
        chk("mr_co", 64'(bus.co), 64'd0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin tick(); if (bus.out_valid) cnt++; end
        chk("mr_no_valid", 64'(cnt), 64'd0);

        op1(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
        op1(32'h1234_5678, 32'h1111_1111, 1'b1, 33'h0_2345_678A);
        op1(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 33'h1_0000_0000);

        for (int i = 0; i < 1000; i++) begin
            accept($urandom, $urandom, 1'($urandom));
            popped = 0;
            t = 0;
            while (!popped && t < 200) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                popped = bus.out_valid && bus.out_ready;
                tick();
                t++;
            end
            bus.out_ready = 1'b0;
            chk("rnd_pop", 64'(popped), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
